// File: rtl/button_event_decoder_pkg.sv
// ============================================================================
// Module : button_event_pkg
// Brief  : State encodings, default timing constants and timer sizing helper
//          shared by the button event decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_event_pkg;

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_PRESSED        = 3'd1,
      ST_LONG_HELD      = 3'd2,
      ST_WAIT_SECOND    = 3'd3,
      ST_SECOND_PRESSED = 3'd4
   } state_t;

   localparam int unsigned DEF_LONG_PRESS_CYCLES = 250000;
   localparam int unsigned DEF_DOUBLE_GAP_CYCLES = 100000;
   localparam int unsigned DEF_COUNT_WIDTH       = 8;

   // One shared timer serves both the long-press and the double-gap windows.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_decoder_if.sv
// ============================================================================
// Module : button_event_decoder_if
// Brief  : Button level in, event pulses / held level / press count out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface button_event_decoder_if #(
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   debounced;
   logic                   short_pulse;
   logic                   long_pulse;
   logic                   double_pulse;
   logic                   held;
   logic [COUNT_WIDTH-1:0] press_count;

   modport master (
      output debounced,
      input  short_pulse, long_pulse, double_pulse, held, press_count
   );

   modport slave (
      input  debounced,
      output short_pulse, long_pulse, double_pulse, held, press_count
   );
endinterface

`default_nettype wire

// File: rtl/button_event_decoder_edge_detect.sv
// ============================================================================
// Module : edge_detect
// Brief  : Rise/fall detector; history resets high so a level held through
//          reset never reads as a press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_detect (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic level,
   output logic      rise,
   output logic      fall
);
   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b1;
      else     r_prev <= level;
   end

   assign rise = level & ~r_prev;
   assign fall = ~level & r_prev;
endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module : button_event_decoder
// Brief  : Classifies debounced presses as short, long or double; emits
//          registered one-cycle pulses, a held level and a press count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int unsigned DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES,
   parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
   input wire logic              clk,
   input wire logic              rst,
   button_event_decoder_if.slave bus
);
   localparam int unsigned   TW          = timer_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES);
   localparam logic [TW-1:0] C_LONG_LAST = TW'(LONG_PRESS_CYCLES - 1);
   localparam logic [TW-1:0] C_GAP_LAST  = TW'(DOUBLE_GAP_CYCLES - 1);

   state_t                 r_state,  w_state_nxt;
   logic [TW-1:0]          r_timer,  w_timer_nxt;
   logic [COUNT_WIDTH-1:0] r_count,  w_count_nxt;
   logic                   r_short,  w_short_nxt;
   logic                   r_long,   w_long_nxt;
   logic                   r_double, w_double_nxt;
   logic                   r_held,   w_held_nxt;
   logic                   w_rise,   w_fall;

   edge_detect u_edge_detect (
      .clk   (clk),
      .rst   (rst),
      .level (bus.debounced),
      .rise  (w_rise),
      .fall  (w_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_timer  <= '0;
         r_count  <= '0;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         r_held   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_count  <= w_count_nxt;
         r_short  <= w_short_nxt;
         r_long   <= w_long_nxt;
         r_double <= w_double_nxt;
         r_held   <= w_held_nxt;
      end
   end

   // In the pressed states the previous level is always high, so a fall
   // is exactly the first low sample.
   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_count_nxt  = r_count;
      w_short_nxt  = 1'b0;
      w_long_nxt   = 1'b0;
      w_double_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_PRESSED;
               w_timer_nxt = '0;
               w_count_nxt = r_count + COUNT_WIDTH'(1);
            end
         end
         ST_PRESSED: begin
            if (w_fall) begin
               w_state_nxt = ST_WAIT_SECOND;
               w_timer_nxt = '0;
            end else if (r_timer == C_LONG_LAST) begin
               w_long_nxt  = 1'b1;
               w_state_nxt = ST_LONG_HELD;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         ST_LONG_HELD: begin
            if (w_fall) w_state_nxt = ST_IDLE;
         end
         ST_WAIT_SECOND: begin
            if (w_rise) begin
               w_state_nxt = ST_SECOND_PRESSED;
               w_count_nxt = r_count + COUNT_WIDTH'(1);
            end else if (r_timer == C_GAP_LAST) begin
               w_short_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         ST_SECOND_PRESSED: begin
            if (w_fall) begin
               w_double_nxt = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
      w_held_nxt = (w_state_nxt == ST_LONG_HELD);
   end

   assign bus.short_pulse  = r_short;
   assign bus.long_pulse   = r_long;
   assign bus.double_pulse = r_double;
   assign bus.held         = r_held;
   assign bus.press_count  = r_count;
endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ============================================================================
// Module : tb_button_event_decoder
// Brief  : Directed, table-driven self-checking bench for button_event_decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_event_decoder;
   localparam int LP = 8;
   localparam int DG = 6;
   localparam int CW = 8;

   typedef struct {
      string name;
      int    l0, l1, l2, l3, l4;
      int    e_short, e_long, e_double, e_held, e_first, e_count;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   button_event_decoder_if #(.COUNT_WIDTH(CW)) bus ();

   button_event_decoder #(
      .LONG_PRESS_CYCLES (LP),
      .DOUBLE_GAP_CYCLES (DG),
      .COUNT_WIDTH       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc, n_short, n_long, n_double, n_held, n_multi, first_k;
   vec_t vecs [9];

   function automatic vec_t mk(string n, int a, int b, int c, int d, int e,
                               int es, int el, int ed, int eh, int ef, int ec);
      vec_t v;
      v.name = n; v.l0 = a; v.l1 = b; v.l2 = c; v.l3 = d; v.l4 = e;
      v.e_short = es; v.e_long = el; v.e_double = ed;
      v.e_held = eh; v.e_first = ef; v.e_count = ec;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; n_short = 0; n_long = 0; n_double = 0;
      n_held = 0; n_multi = 0; first_k = -1;
   endtask

   task automatic step(input logic lvl);
      bus.debounced = lvl;
      @(posedge clk);
      #1;
      if (bus.short_pulse)  n_short++;
      if (bus.long_pulse)   n_long++;
      if (bus.double_pulse) n_double++;
      if (bus.held)         n_held++;
      if (int'(bus.short_pulse) + int'(bus.long_pulse) + int'(bus.double_pulse) > 1) n_multi++;
      if (first_k < 0 && (bus.short_pulse || bus.long_pulse || bus.double_pulse)) first_k = cyc;
      cyc++;
   endtask

   task automatic do_reset(input logic lvl);
      rst = 1'b1;
      bus.debounced = lvl;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stats();
   endtask

   task automatic run_vec(input vec_t v);
      repeat (v.l0) step(1'b0);
      repeat (v.l1) step(1'b1);
      repeat (v.l2) step(1'b0);
      repeat (v.l3) step(1'b1);
      repeat (v.l4) step(1'b0);
   endtask

   initial begin
      // Levels alternate low/high/low/high/low; expectations use the index of
      // the edge (from 0 after reset) whose evaluation raises the pulse.
      vecs[0] = mk("short",         2,  3, 10, 0,  0,  1, 0, 0, 0, 11, 1);
      vecs[1] = mk("long",          2, 12,  6, 0,  0,  0, 1, 0, 4, 10, 1);
      vecs[2] = mk("double",        2,  3,  2, 3,  6,  0, 0, 1, 0, 10, 2);
      vecs[3] = mk("gap_timeout",   2,  3,  8, 3,  8,  2, 0, 0, 0, 11, 2);
      vecs[4] = mk("gap_edge_rise", 2,  3,  6, 3, 10,  0, 0, 1, 0, 14, 2);
      vecs[5] = mk("gap_past_edge", 2,  3,  7, 3, 10,  2, 0, 0, 0, 11, 2);
      vecs[6] = mk("high_eight",    2,  8, 10, 0,  0,  1, 0, 0, 0, 16, 1);
      vecs[7] = mk("high_nine",     2,  9,  6, 0,  0,  0, 1, 0, 1, 10, 1);
      vecs[8] = mk("second_long",   2,  3,  2, 12, 4,  0, 0, 1, 0, 19, 2);

      // Button held through reset is not a press.
      do_reset(1'b1);
      check("reset_count", int'(bus.press_count), 0);
      check("reset_outputs", int'(bus.short_pulse) + int'(bus.long_pulse) +
            int'(bus.double_pulse) + int'(bus.held), 0);
      repeat (10) step(1'b1);
      check("held_thru_reset_pulses", n_short + n_long + n_double + n_held, 0);
      check("held_thru_reset_count", int'(bus.press_count), 0);
      repeat (2) step(1'b0);
      repeat (3) step(1'b1);
      check("first_real_press_count", int'(bus.press_count), 1);

      foreach (vecs[i]) begin
         do_reset(1'b0);
         run_vec(vecs[i]);
         check({vecs[i].name, ".short"},  n_short,  vecs[i].e_short);
         check({vecs[i].name, ".long"},   n_long,   vecs[i].e_long);
         check({vecs[i].name, ".double"}, n_double, vecs[i].e_double);
         check({vecs[i].name, ".held"},   n_held,   vecs[i].e_held);
         check({vecs[i].name, ".first"},  first_k,  vecs[i].e_first);
         check({vecs[i].name, ".count"},  int'(bus.press_count), vecs[i].e_count);
         check({vecs[i].name, ".exclusive"}, n_multi, 0);
      end

      // Reset asserted while PRESSED: nothing pending may escape.
      do_reset(1'b0);
      repeat (2) step(1'b0);
      repeat (2) step(1'b1);
      rst = 1'b1;
      step(1'b1);
      rst = 1'b0;
      repeat (12) step(1'b0);
      check("mid_reset_pulses", n_short + n_long + n_double + n_held, 0);
      check("mid_reset_count", int'(bus.press_count), 0);

      // 256 short presses wrap the count back to zero.
      do_reset(1'b0);
      repeat (2) step(1'b0);
      for (int i = 0; i < 256; i++) begin
         repeat (2) step(1'b1);
         repeat (7) step(1'b0);
         if (i == 254) check("wrap_count_255", int'(bus.press_count), 255);
      end
      check("wrap_count_0", int'(bus.press_count), 0);
      check("wrap_shorts", n_short, 256);
      check("wrap_doubles", n_double + n_long, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
